rx_timer: RTL and testbench
===========================

// Module: rx_timer
//
// PURPOSE
//   Bit-timing stage for the UART receive path. Sits between the receiver control
//   unit (rcu) and the shift register / stop-bit checker.
//   While rcu holds enable_timer high, the block counts clock cycles per bit period.
//   It pulses shift_strobe once per bit, for DATA_BITS data bits plus one stop bit.
//   After the stop-bit strobe it pulses packet_done for one cycle back to rcu.
//
// PARAMETERS
//   CLKS_PER_BIT  10  clock cycles per serial bit period; legal range >= 2
//   DATA_BITS     8   data bits per frame; legal range 1..16
//                     (the stop bit is always 1 extra strobe)
//
// PORTS
//   clk           in   1   system clock, rising-edge
//   rst           in   1   asynchronous reset, active-high
//   enable_timer  in   1   from rcu; high for the whole frame-receive window
//   shift_strobe  out  1   one-cycle pulse at the end of each bit period
//   packet_done   out  1   one-cycle pulse after the final (stop-bit) strobe
//   bit_count     out  $clog2(DATA_BITS+2)  strobes already taken in this frame
//
// BEHAVIOUR
//   - Internal state:
//       clk_cnt  0..CLKS_PER_BIT, width $clog2(CLKS_PER_BIT+1)
//       bit_cnt  0..DATA_BITS, drives bit_count
//       FSM      IDLE / COUNT / DONE
//   - Reset (rst=1): FSM=IDLE, clk_cnt=0, bit_cnt=0.
//     All outputs are 0 for as long as rst is high.
//     rst dominates every other condition, including mid-frame.
//   - Outputs are pure decodes of registered state; there is no combinational path
//     from enable_timer to any output.
//       shift_strobe = (FSM==COUNT) && (clk_cnt==CLKS_PER_BIT)
//       packet_done  = (FSM==DONE)
//       bit_count    = bit_cnt
//   - IDLE: counters are held at 0.
//       enable_timer=1 at an edge -> COUNT, clk_cnt<=1.
//   - COUNT, enable_timer=1 at an edge:
//       * clk_cnt<CLKS_PER_BIT -> clk_cnt<=clk_cnt+1.
//       * clk_cnt==CLKS_PER_BIT (strobe cycle) and bit_cnt<DATA_BITS
//           -> clk_cnt<=1, bit_cnt<=bit_cnt+1 (wrap into the next bit).
//       * clk_cnt==CLKS_PER_BIT and bit_cnt==DATA_BITS (stop-bit strobe)
//           -> DONE, clk_cnt<=0, bit_cnt<=0.
//   - COUNT, enable_timer=0 at an edge (abort, e.g. rcu sees a framing error):
//       -> IDLE, counters cleared.
//       No packet_done is produced, even if the same cycle is a strobe cycle.
//   - DONE: lasts exactly one cycle, then -> IDLE unconditionally.
//       If enable_timer is still high, the next edge restarts COUNT from clk_cnt=1.
//   - Latency, counting edges from the first edge with enable_timer=1 as edge 1:
//       * strobe k is high in the cycle after edge k*CLKS_PER_BIT,
//         for k = 1..DATA_BITS+1.
//       * packet_done is high in the cycle after edge (DATA_BITS+1)*CLKS_PER_BIT+1.
//       * Defaults: strobes after edges 10, 20, ..., 90; packet_done after edge 91.
//         That is 9 strobes and 1 done per frame.
//   - Counters never exceed their maxima, and the two outputs are never high in
//     the same cycle.
//   - Reset asserted mid-frame: outputs drop to 0 immediately (asynchronously).
//     After release the block is in IDLE and waits for enable_timer.
//
// TESTING
//   1. Reset: rst=1 for 2 cycles, then release with enable_timer=0
//      -> all outputs 0, and they stay 0 for 20 cycles.
//   2. Full frame with defaults: raise enable_timer at a negedge and hold it
//      -> shift_strobe pulses after edges 10, 20, ..., 90;
//         bit_count steps 0->1->...->8 after edges 11, 21, ..., 81;
//         packet_done is high for 1 cycle after edge 91; 9 strobes in total.
//   3. Abort: drop enable_timer after edge 45
//      -> no further strobes, no packet_done;
//         bit_count=0 and the FSM is in IDLE by the next edge.
//   4. Back-to-back frames: keep enable_timer high through DONE
//      -> second frame strobes after edges 102, 112, ..., 182;
//         second packet_done after edge 183.
//   5. Mid-frame reset: assert rst asynchronously after edge 55
//      -> outputs are 0 at once; after release with enable_timer=1,
//         the first strobe comes CLKS_PER_BIT edges later.
//   6. Parameter sweep with CLKS_PER_BIT=4, DATA_BITS=5
//      -> strobes after edges 4, 8, ..., 24; packet_done after edge 25.

Source files
------------

// File: rtl/rx_timer_if.sv
// Handshake between the receiver control unit and the bit-timing stage.
// The control unit uses the master modport and the timer uses the slave modport.
interface rx_timer_if #(
    parameter int DATA_BITS = 8
);
    localparam int BCW = $clog2(DATA_BITS + 2);

    logic           enable_timer;
    logic           shift_strobe;
    logic           packet_done;
    logic [BCW-1:0] bit_count;

    modport master (
        output enable_timer,
        input  shift_strobe,
        input  packet_done,
        input  bit_count
    );

    modport slave (
        input  enable_timer,
        output shift_strobe,
        output packet_done,
        output bit_count
    );
endinterface

// File: rtl/rx_timer.sv
// UART receive bit timer. It issues one strobe per data bit and one for the stop bit,
// then pulses packet_done. All outputs are decoded from registered state.
module rx_timer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic         clk,
    input  logic         rst,
    rx_timer_if.slave    tmr
);
    localparam int CW  = $clog2(CLKS_PER_BIT + 1);
    localparam int BCW = $clog2(DATA_BITS + 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0]  CLK_MAX = CW'(CLKS_PER_BIT);
    localparam logic [BCW-1:0] BIT_MAX = BCW'(DATA_BITS);

    logic [1:0]     state_q,   state_d;
    logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;

    logic at_bit_end;
    assign at_bit_end = (clk_cnt_q == CLK_MAX);

    always_comb begin
        // NOTE: defaults first so every path assigns every signal, so no latches are inferred.
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (tmr.enable_timer) begin
                    state_d   = ST_COUNT;
                    clk_cnt_d = CW'(1);
                end
            end
            ST_COUNT: begin
                if (!tmr.enable_timer) begin
                    // An abort wins even on the stop-bit strobe, so no done pulse is produced.
                    state_d   = ST_IDLE;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end else if (!at_bit_end) begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end else if (bit_cnt_q != BIT_MAX) begin
                    clk_cnt_d = CW'(1);
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end else begin
                    state_d   = ST_DONE;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign tmr.shift_strobe = (state_q == ST_COUNT) && at_bit_end;
    assign tmr.packet_done  = (state_q == ST_DONE);
    assign tmr.bit_count    = bit_cnt_q;
endmodule

// File: tb/tb_rx_timer.sv
// Directed bench for rx_timer. It runs a default instance (10 clocks/bit, 8 data bits)
// and a small instance (4 clocks/bit, 5 data bits), sampling on the falling edge.
module tb_rx_timer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   nstrobe;
    int   ndone;

    always #5 clk = ~clk;

    rx_timer_if #(.DATA_BITS(8)) bus_a ();
    rx_timer_if #(.DATA_BITS(5)) bus_b ();

    rx_timer #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut_a (.clk(clk), .rst(rst), .tmr(bus_a));
    rx_timer #(.CLKS_PER_BIT(4),  .DATA_BITS(5)) dut_b (.clk(clk), .rst(rst), .tmr(bus_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // m counts edges since enable_timer was first seen high; m=0 means the block is idle.
    function automatic int e_strobe(input int m, input int cpb, input int db);
        return (m >= 1 && m % cpb == 0 && m <= (db + 1) * cpb) ? 1 : 0;
    endfunction

    function automatic int e_done(input int m, input int cpb, input int db);
        return (m == (db + 1) * cpb + 1) ? 1 : 0;
    endfunction

    function automatic int e_bc(input int m, input int cpb, input int db);
        return (m > cpb && m <= (db + 1) * cpb) ? (m - 1) / cpb : 0;
    endfunction

    task automatic sample(input bit sel, output logic s, output logic d, output logic [31:0] bc);
        s  = sel ? bus_b.shift_strobe : bus_a.shift_strobe;
        d  = sel ? bus_b.packet_done  : bus_a.packet_done;
        bc = sel ? 32'(bus_b.bit_count) : 32'(bus_a.bit_count);
    endtask

    task automatic check_zero(input bit sel, input string tag);
        logic s, d;
        logic [31:0] bc;
        sample(sel, s, d, bc);
        check({tag, ".strobe"}, 32'(s), 0);
        check({tag, ".done"},   32'(d), 0);
        check({tag, ".bc"},     bc,     0);
    endtask

    task automatic step(input bit sel, input int m, input int cpb, input int db, input string tag);
        logic s, d;
        logic [31:0] bc;
        @(posedge clk);
        @(negedge clk);
        sample(sel, s, d, bc);
        if (s) nstrobe++;
        if (d) ndone++;
        check($sformatf("%s.m%0d.strobe", tag, m), 32'(s), 32'(e_strobe(m, cpb, db)));
        check($sformatf("%s.m%0d.done",   tag, m), 32'(d), 32'(e_done(m, cpb, db)));
        check($sformatf("%s.m%0d.bc",     tag, m), bc,     32'(e_bc(m, cpb, db)));
    endtask

    initial begin
        rst = 1'b1;
        bus_a.enable_timer = 1'b0;
        bus_b.enable_timer = 1'b0;

        // Reset held for two cycles, then twenty idle cycles.
        repeat (2) @(negedge clk);
        check_zero(0, "rst_a");
        check_zero(1, "rst_b");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_zero(0, $sformatf("idle_a%0d", i));
            check_zero(1, $sformatf("idle_b%0d", i));
        end

        // Full frame followed by a back-to-back frame with enable held through DONE.
        bus_a.enable_timer = 1'b1;
        nstrobe = 0; ndone = 0;
        for (int n = 1; n <= 92; n++) step(0, n, 10, 8, "frame1");
        check("frame1.strobes", 32'(nstrobe), 9);
        check("frame1.dones",   32'(ndone),   1);
        nstrobe = 0; ndone = 0;
        for (int m = 1; m <= 93; m++) step(0, m, 10, 8, "frame2");
        check("frame2.strobes", 32'(nstrobe), 9);
        check("frame2.dones",   32'(ndone),   1);
        bus_a.enable_timer = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 10, 8, "gap1");

        // Abort mid-frame after edge 45.
        bus_a.enable_timer = 1'b1;
        for (int m = 1; m <= 45; m++) step(0, m, 10, 8, "pre_abort");
        bus_a.enable_timer = 1'b0;
        step(0, 0, 10, 8, "abort");
        check("abort.state_idle", 32'(dut_a.state_q), 0);
        nstrobe = 0; ndone = 0;
        for (int i = 0; i < 30; i++) step(0, 0, 10, 8, "post_abort");
        check("post_abort.strobes", 32'(nstrobe), 0);

        // Abort during the stop-bit strobe cycle must suppress packet_done.
        bus_a.enable_timer = 1'b1;
        for (int m = 1; m <= 90; m++) step(0, m, 10, 8, "pre_stop_abort");
        bus_a.enable_timer = 1'b0;
        ndone = 0;
        for (int i = 0; i < 5; i++) step(0, 0, 10, 8, "stop_abort");
        check("stop_abort.dones", 32'(ndone), 0);

        // Asynchronous reset in the middle of a frame.
        bus_a.enable_timer = 1'b1;
        for (int m = 1; m <= 55; m++) step(0, m, 10, 8, "pre_reset");
        #1 rst = 1'b1;
        #1 check_zero(0, "async_rst");
        check("async_rst.state_idle", 32'(dut_a.state_q), 0);
        repeat (2) @(negedge clk);
        check_zero(0, "rst_held");
        rst = 1'b0;
        nstrobe = 0;
        for (int m = 1; m <= 12; m++) step(0, m, 10, 8, "after_reset");
        check("after_reset.strobes", 32'(nstrobe), 1);
        bus_a.enable_timer = 1'b0;
        step(0, 0, 10, 8, "after_reset_idle");

        // Second configuration: 4 clocks per bit, 5 data bits.
        bus_b.enable_timer = 1'b1;
        nstrobe = 0; ndone = 0;
        for (int m = 1; m <= 27; m++) step(1, m, 4, 5, "small");
        check("small.strobes", 32'(nstrobe), 6);
        check("small.dones",   32'(ndone),   1);
        bus_b.enable_timer = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 0, 4, 5, "small_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
